// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by the fetch FSM and its performance counters.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_HAND = 2'd2,
    S_WAIT = 2'd3
  } ifu_state_t;

  localparam logic [1:0]  AXI_RESP_OKAY      = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h3000_0000;
  localparam logic [31:0] FAULT_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch_unit_perf.sv
// Free-running performance counters for the fetch unit.
// Counts completed handoffs and bus-wait cycles; both wrap silently at 2^32.
module ifu_perf_counters (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_en_i,
  input  logic        wait_en_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] wait_cnt_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] wait_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      wait_cnt_q  <= 32'd0;
    end else begin
      if (fetch_en_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (wait_en_i)  wait_cnt_q  <= wait_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign wait_cnt_o  = wait_cnt_q;

endmodule

// File: rtl/ifu_fetch_unit.sv
// Non-pipelined instruction fetch unit: reads one word per PC over AXI4-Lite,
// hands it to decode, then waits for the next PC before fetching again.
module ifu_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] FAULT_INST = FAULT_INST_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] ifu_to_idu_pc,
  output logic        ifu_valid,
  input  logic        ifu_ready,
  output logic        fetch_fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        npc_ready,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        ifu_valid_q, ifu_valid_d;
  logic        npc_ready_q, npc_ready_d;
  logic        fault_q, fault_d;
  logic        fetch_en;
  logic        wait_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_AR;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ifu_valid_q <= 1'b0;
      npc_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      ifu_valid_q <= ifu_valid_d;
      npc_ready_q <= npc_ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    ifu_valid_d = ifu_valid_q;
    npc_ready_d = npc_ready_q;
    fault_d     = fault_q;
    fetch_en    = 1'b0;
    wait_en     = (state_q == S_AR) || (state_q == S_R);

    case (state_q)
      S_AR: begin
        // After reset or recovery arvalid is low here; raise it first, then wait for the slave.
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
        end else if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (rvalid && rready_q) begin
          inst_d      = (rresp == AXI_RESP_OKAY) ? rdata : FAULT_INST;
          fault_d     = (rresp != AXI_RESP_OKAY);
          rready_d    = 1'b0;
          ifu_valid_d = 1'b1;
          state_d     = S_HAND;
        end
      end
      S_HAND: begin
        if (ifu_valid_q && ifu_ready) begin
          ifu_valid_d = 1'b0;
          npc_ready_d = 1'b1;
          fetch_en    = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (npc_valid && npc_ready_q) begin
          npc_ready_d = 1'b0;
          pc_d        = npc;
          if (npc[1:0] == 2'b00) begin
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end else begin
            // Misaligned target: report a fault without touching the bus.
            inst_d      = FAULT_INST;
            fault_d     = 1'b1;
            ifu_valid_d = 1'b1;
            state_d     = S_HAND;
          end
        end
      end
      default: begin
        state_d     = S_AR;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        ifu_valid_d = 1'b0;
        npc_ready_d = 1'b0;
      end
    endcase
  end

  ifu_perf_counters u_perf (
    .clock       (clock),
    .reset       (reset),
    .fetch_en_i  (fetch_en),
    .wait_en_i   (wait_en),
    .fetch_cnt_o (perf_fetch_cnt),
    .wait_cnt_o  (perf_wait_cnt)
  );

  assign araddr        = pc_q;
  assign arvalid       = arvalid_q;
  assign rready        = rready_q;
  assign inst          = inst_q;
  assign ifu_to_idu_pc = pc_q;
  assign ifu_valid     = ifu_valid_q;
  assign npc_ready     = npc_ready_q;
  assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed self-checking bench for ifu_fetch_unit; the bench plays both the
// AXI4-Lite slave and the decode/execute side, cycle by cycle.
module tb_ifu_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] ifu_to_idu_pc;
  logic        ifu_valid;
  logic        ifu_ready;
  logic        fetch_fault;
  logic        npc_valid;
  logic [31:0] npc;
  logic        npc_ready;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;

  int          compareCount  = 0;
  int          mismatchCount = 0;
  logic [31:0] waitBase;

  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam logic [31:0] F_INST = 32'h0000_0000;

  ifu_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .inst           (inst),
    .ifu_to_idu_pc  (ifu_to_idu_pc),
    .ifu_valid      (ifu_valid),
    .ifu_ready      (ifu_ready),
    .fetch_fault    (fetch_fault),
    .npc_valid      (npc_valid),
    .npc            (npc),
    .npc_ready      (npc_ready),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ar, input logic rv, input logic [31:0] rd,
                               input logic [1:0] rr, input logic ir, input logic nv,
                               input logic [31:0] np);
    arready   = ar;
    rvalid    = rv;
    rdata     = rd;
    rresp     = rr;
    ifu_ready = ir;
    npc_valid = nv;
    npc       = np;
  endtask

  task automatic checkHand(input string tag, input logic [31:0] expInst, input logic [31:0] expPc,
                           input logic expFault);
    checkOutput({tag, "_valid"}, {31'd0, ifu_valid}, 32'd1);
    checkOutput({tag, "_inst"}, inst, expInst);
    checkOutput({tag, "_pc"}, ifu_to_idu_pc, expPc);
    checkOutput({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, expFault});
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    checkOutput("rst_arvalid", {31'd0, arvalid}, 32'd0);
    checkOutput("rst_rready", {31'd0, rready}, 32'd0);
    checkOutput("rst_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    checkOutput("rst_npc_ready", {31'd0, npc_ready}, 32'd0);
    checkOutput("rst_fault", {31'd0, fetch_fault}, 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_araddr", araddr, RST_PC);
    checkOutput("rst_fetch_cnt", perf_fetch_cnt, 32'd0);
    checkOutput("rst_wait_cnt", perf_wait_cnt, 32'd0);

    // Basic zero-wait fetch from the reset PC
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("t1_arvalid", {31'd0, arvalid}, 32'd1);
    checkOutput("t1_araddr", araddr, RST_PC);
    applyStimulus(1'b1, 1'b1, 32'h0000_0413, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("t1_ar_done", {31'd0, arvalid}, 32'd0);
    checkOutput("t1_rready", {31'd0, rready}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0413, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkHand("t1_hand", 32'h0000_0413, RST_PC, 1'b0);
    checkOutput("t1_rready_low", {31'd0, rready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("t1_valid_drop", {31'd0, ifu_valid}, 32'd0);
    checkOutput("t1_fetch_cnt", perf_fetch_cnt, 32'd1);
    checkOutput("t1_wait_cnt", perf_wait_cnt, 32'd3);
    checkOutput("t1_npc_ready", {31'd0, npc_ready}, 32'd1);

    // Accept a new PC, then a slow slave with a stray npc pulse during S_R
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h3000_0100);
    tick();
    checkOutput("t4_npc_ready", {31'd0, npc_ready}, 32'd0);
    checkOutput("t4_arvalid", {31'd0, arvalid}, 32'd1);
    checkOutput("t4_araddr", araddr, 32'h3000_0100);
    waitBase = perf_wait_cnt;
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t2_ar_hold%0d", i), {araddr[31:1], arvalid}, {31'h1800_0080, 1'b1});
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("t2_rready", {30'd0, arvalid, rready}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'hDEAD_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t2_r_wait%0d", i), {29'd0, rready, ifu_valid, npc_ready}, 32'd4);
      applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'h00A0_0093, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkHand("t2_hand", 32'h00A0_0093, 32'h3000_0100, 1'b0);
    checkOutput("t2_wait_delta", perf_wait_cnt - waitBase, 32'd9);

    // Decoder stalls for five cycles
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkHand($sformatf("t3_stall%0d", i), 32'h00A0_0093, 32'h3000_0100, 1'b0);
      checkOutput($sformatf("t3_npc_ready%0d", i), {31'd0, npc_ready}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("t3_valid_drop", {31'd0, ifu_valid}, 32'd0);
    checkOutput("t3_fetch_cnt", perf_fetch_cnt, 32'd2);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("t3_no_dup", {30'd0, ifu_valid, npc_ready}, 32'd1);

    // Bus error response, then a misaligned next PC
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h3000_0200);
    tick();
    checkOutput("t5_araddr", araddr, 32'h3000_0200);
    applyStimulus(1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 32'd0);
    tick();
    checkHand("t5_slverr", F_INST, 32'h3000_0200, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("t5_fault_held", {31'd0, fetch_fault}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h3000_0102);
    tick();
    checkHand("t5_misalign", F_INST, 32'h3000_0102, 1'b1);
    checkOutput("t5_no_arvalid", {31'd0, arvalid}, 32'd0);
    checkOutput("t5_fetch_cnt", perf_fetch_cnt, 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("t5_fetch_cnt2", perf_fetch_cnt, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h3000_0300);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkHand("t5_recover", 32'h0000_0013, 32'h3000_0300, 1'b0);

    // Reset while a read response is pending in S_R
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h3000_0400);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("t6_in_r", {31'd0, rready}, 32'd1);
    checkOutput("t6_pre_cnt", perf_fetch_cnt, 32'd5);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'hBAD0_BAD0, 2'b00, 1'b0, 1'b0, 32'd0);
    tick();
    checkOutput("t6_rst_outs", {28'd0, arvalid, rready, ifu_valid, npc_ready}, 32'd0);
    checkOutput("t6_rst_fetch", perf_fetch_cnt, 32'd0);
    checkOutput("t6_rst_wait", perf_wait_cnt, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("t6_arvalid", {31'd0, arvalid}, 32'd1);
    checkOutput("t6_araddr", araddr, RST_PC);
    checkOutput("t6_rready", {31'd0, rready}, 32'd0);
    tick();
    checkOutput("t6_ignore_r", {31'd0, ifu_valid}, 32'd0);
    checkOutput("t6_inst", inst, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
